// File: rtl/store_buffer.sv
// Write-posting store buffer in front of single-port data_memory.
// Queues pipeline stores, drains them when loads leave the port free, forwards youngest match to loads.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 16,
   parameter int DW    = 16,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_ready,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_ready,
   output logic [DW-1:0] ld_data,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          empty,
   output logic [CW-1:0] count
);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } sb_entry_t;

   typedef enum logic [1:0] {
      M_IDLE,
      M_LOAD,
      M_DRAIN
   } port_mode_e;

   sb_entry_t [DEPTH-1:0] ent_q;
   logic [PW-1:0]         head_q;
   logic [PW-1:0]         tail_q;
   logic [CW-1:0]         count_q;

   port_mode_e            mode;
   logic                  full;
   logic                  push;
   logic                  pop;

   logic [DEPTH-1:0]      hit;
   logic [PW-1:0]         sel_idx;
   logic                  fwd_hit;
   logic [DW-1:0]         fwd_data;

   assign full     = (count_q == CW'(DEPTH));
   assign st_ready = !full;
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign push     = st_valid && !full;
   assign pop      = (mode == M_DRAIN);

   // A full buffer always wins the port so stores can never deadlock behind loads.
   always_comb begin
      mode = M_IDLE;
      if (full)
         mode = M_DRAIN;
      else if (ld_valid)
         mode = M_LOAD;
      else if (!empty)
         mode = M_DRAIN;
   end

   always_comb begin
      mem_addr  = ld_addr;
      mem_wdata = '0;
      mem_we    = 1'b0;
      ld_ready  = !full;
      if (mode == M_DRAIN) begin
         mem_addr  = ent_q[head_q].addr;
         mem_wdata = ent_q[head_q].data;
         mem_we    = 1'b1;
      end
   end

   // Per-entry match: an entry is live when its distance from head is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      logic [PW-1:0] age;
      assign age    = PW'(i) - head_q;
      assign hit[i] = ({1'b0, age} < count_q) && (ent_q[i].addr == ld_addr);
   end

   // Walk oldest to youngest so the last hit seen is the youngest store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      sel_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         sel_idx = head_q + PW'(k);
         if (hit[sel_idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_q[sel_idx].data;
         end
      end
   end

   assign ld_data = fwd_hit ? fwd_data : mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push)
            tail_q <= tail_q + 1'b1;
         if (pop)
            head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry payload needs no reset; liveness comes from head/count alone.
   always_ff @(posedge clk) begin
      if (push && !rst)
         ent_q[tail_q] <= '{addr: st_addr, data: st_data};
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: memory model, write scoreboard with arbitration/forwarding model, directed scenarios.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_ready;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic          ld_ready;
   logic [DW-1:0] ld_data;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic          empty;
   logic [2:0]    count;

   logic [DW-1:0] mem [0:65535];

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_wr[$];
   logic [DW-1:0] log20[$];
   int            n_chk = 0;
   int            n_err = 0;

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         mem[mem_addr] <= mem_wdata;
         if (mem_addr == 16'h0020)
            log20.push_back(mem_wdata);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: the write queue is the model of buffer contents; arbitration and forwarding follow from it.
   always @(negedge clk) begin
      int            n;
      logic          full_m;
      logic          drain_m;
      logic [DW-1:0] exp_ld;
      if (rst) begin
         exp_wr.delete();
      end else begin
         n       = exp_wr.size();
         full_m  = (n == DEPTH);
         drain_m = full_m || (!ld_valid && n != 0);
         chk("mon_count", 32'(count), 32'(n));
         chk("mon_st_ready", 32'(st_ready), 32'(!full_m));
         chk("mon_ld_ready", 32'(ld_ready), 32'(!full_m));
         chk("mon_mem_we", 32'(mem_we), 32'(drain_m));
         if (ld_valid && !full_m) begin
            exp_ld = mem[ld_addr];
            for (int i = 0; i < n; i++)
               if (exp_wr[i].a == ld_addr) exp_ld = exp_wr[i].d;
            chk("mon_ld_data", 32'(ld_data), 32'(exp_ld));
         end
         if (mem_we === 1'b1) begin
            if (n == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL mon_spurious_write: addr %h data %h with nothing pending", mem_addr, mem_wdata);
            end else begin
               chk("mon_wr_addr", 32'(mem_addr), 32'(exp_wr[0].a));
               chk("mon_wr_data", 32'(mem_wdata), 32'(exp_wr[0].d));
               void'(exp_wr.pop_front());
            end
         end
         if (st_valid && !full_m)
            exp_wr.push_back('{a: st_addr, d: st_data});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input int lim);
      int c = 0;
      while (empty !== 1'b1 && c < lim) begin
         tick();
         c++;
      end
      chk("drain_bound", 32'(empty), 32'd1);
   endtask

   initial begin
      int issued;
      int guard;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h0030] = 16'h1234;
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0;
      tick(); tick();
      rst = 1'b0;

      // reset, then idle
      repeat (5) begin
         @(negedge clk);
         chk("rst_count", 32'(count), 32'd0);
         chk("rst_empty", 32'(empty), 32'd1);
         chk("rst_st_ready", 32'(st_ready), 32'd1);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_ld_ready", 32'(ld_ready), 32'd1);
         tick();
      end

      // single store, drains in the cycle after the push
      st_valid = 1'b1; st_addr = 16'h0010; st_data = 16'hBEEF;
      @(negedge clk); chk("s1_st_ready", 32'(st_ready), 32'd1);
      tick(); st_valid = 1'b0;
      @(negedge clk);
      chk("s1_mem_we", 32'(mem_we), 32'd1);
      chk("s1_mem_addr", 32'(mem_addr), 32'h0010);
      chk("s1_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      chk("s1_empty_busy", 32'(empty), 32'd0);
      tick();
      @(negedge clk); chk("s1_empty_after", 32'(empty), 32'd1);
      tick(); ld_valid = 1'b1; ld_addr = 16'h0010;
      @(negedge clk); chk("s1_readback", 32'(ld_data), 32'hBEEF);
      tick(); ld_valid = 1'b0;

      // fill while a load holds the port; full forces a drain
      ld_valid = 1'b1; ld_addr = 16'h0100;
      for (int i = 0; i < 4; i++) begin
         st_valid = 1'b1; st_addr = 16'(i + 1); st_data = 16'(i + 1) * 16'h1111;
         tick();
      end
      st_valid = 1'b0;
      @(negedge clk);
      chk("full_count", 32'(count), 32'd4);
      chk("full_st_ready", 32'(st_ready), 32'd0);
      chk("full_ld_ready", 32'(ld_ready), 32'd0);
      chk("full_mem_we", 32'(mem_we), 32'd1);
      chk("full_mem_addr", 32'(mem_addr), 32'h0001);
      chk("full_mem_wdata", 32'(mem_wdata), 32'h1111);
      tick();
      @(negedge clk);
      chk("full_count_after", 32'(count), 32'd3);
      chk("full_ld_ready_after", 32'(ld_ready), 32'd1);
      chk("full_ld_data", 32'(ld_data), 32'h0000);
      tick(); ld_valid = 1'b0;
      wait_empty(10);
      chk("full_mem1", 32'(mem[1]), 32'h1111);
      chk("full_mem2", 32'(mem[2]), 32'h2222);
      chk("full_mem3", 32'(mem[3]), 32'h3333);
      chk("full_mem4", 32'(mem[4]), 32'h4444);

      // forwarding of the youngest match; same-cycle push invisible
      ld_valid = 1'b1; ld_addr = 16'h0020;
      st_valid = 1'b1; st_addr = 16'h0020; st_data = 16'hAAAA;
      @(negedge clk); chk("fwd_none", 32'(ld_data), 32'h0000);
      tick(); st_data = 16'hBBBB;
      @(negedge clk); chk("fwd_older", 32'(ld_data), 32'hAAAA);
      tick(); st_valid = 1'b0;
      @(negedge clk);
      chk("fwd_youngest", 32'(ld_data), 32'hBBBB);
      chk("fwd_count", 32'(count), 32'd2);
      tick(); ld_valid = 1'b0;
      wait_empty(10);
      chk("fwd_wr_count", 32'(log20.size()), 32'd2);
      if (log20.size() == 2) begin
         chk("fwd_wr_first", 32'(log20[0]), 32'hAAAA);
         chk("fwd_wr_second", 32'(log20[1]), 32'hBBBB);
      end
      ld_valid = 1'b1; ld_addr = 16'h0020;
      @(negedge clk); chk("fwd_mem", 32'(ld_data), 32'hBBBB);
      tick(); ld_valid = 1'b0;

      // pointer wrap with interleaved loads
      issued = 0; guard = 0;
      while (issued < 10 && guard < 200) begin
         ld_valid = 1'($urandom_range(0, 1));
         ld_addr  = 16'h0040 + 16'($urandom_range(0, 9));
         if (exp_wr.size() < DEPTH && $urandom_range(0, 3) != 0) begin
            st_valid = 1'b1; st_addr = 16'h0040 + 16'(issued); st_data = 16'hC000 + 16'(issued);
            issued++;
         end else begin
            st_valid = 1'b0;
         end
         @(negedge clk); chk("wrap_count_max", 32'(count <= 3'd4), 32'd1);
         tick();
         guard++;
      end
      chk("wrap_issued", 32'(issued), 32'd10);
      st_valid = 1'b0; ld_valid = 1'b0;
      wait_empty(10);
      for (int i = 0; i < 10; i++) begin
         ld_valid = 1'b1; ld_addr = 16'h0040 + 16'(i);
         @(negedge clk); chk("wrap_readback", 32'(ld_data), 32'hC000 + 32'(i));
         tick();
      end
      ld_valid = 1'b0;

      // reset discards pending stores
      ld_valid = 1'b1; ld_addr = 16'h0030;
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1; st_addr = 16'h0030 + 16'(i); st_data = 16'h5555;
         tick();
      end
      st_valid = 1'b0;
      @(negedge clk);
      chk("rst3_count", 32'(count), 32'd3);
      chk("rst3_fwd", 32'(ld_data), 32'h5555);
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("rst3_count_after", 32'(count), 32'd0);
      chk("rst3_empty_after", 32'(empty), 32'd1);
      chk("rst3_old_value", 32'(ld_data), 32'h1234);
      tick(); ld_valid = 1'b0;
      repeat (5) begin
         @(negedge clk); chk("rst3_no_write", 32'(mem_we), 32'd0);
         tick();
      end
      chk("rst3_mem30", 32'(mem[16'h0030]), 32'h1234);
      chk("rst3_mem31", 32'(mem[16'h0031]), 32'h0000);
      chk("rst3_mem32", 32'(mem[16'h0032]), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_err);
      $fatal(1, "watchdog");
   end

endmodule
